// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and default constants for the lock supervisor.
package lock_pkg;
    typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_OPEN_CYCLES    = 16;
    localparam int DEF_LOCKOUT_CYCLES = 64;
    localparam int FAIL_W             = 4;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that stops at zero; done flags zero.
module lock_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         count,
    output logic         done
);
    logic [W-1:0] value;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            value <= '0;
        else if (load)
            value <= load_value;
        else if (count && value != '0)
            value <= value - W'(1);
    assign done = (value == '0);
endmodule

// File: rtl/lock_supervisor.sv
// lock_supervisor: door/lockout FSM over code-checker verdicts.
// Optional alarm output enabled by macro LOCK_SUPERVISOR_ALARM_EN.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              result_valid,
    input  logic              unlocked,
    input  logic              wrong_code,
    input  logic              relock,
    output logic              entry_allow,
    output logic              door_open,
    output logic              locked_out,
    output logic [FAIL_W-1:0] fail_count,
    output logic              alarm
);
    localparam int TW = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);
    state_t            state;
    logic              done;
    logic              load;
    logic [TW-1:0]     load_value;
    logic [FAIL_W-1:0] fail_next;
    logic              hit_max;
    assign fail_next = fail_count + FAIL_W'(1);
    assign hit_max   = (fail_next == FAIL_W'(MAX_FAILS));
    // Relock reloads zero so the timer is idle-clean when OPEN ends early.
    assign load = (state == IDLE && result_valid && (unlocked || (wrong_code && hit_max)))
               || (state == OPEN && relock);
    assign load_value = (state == OPEN) ? '0
                      : unlocked ? TW'(OPEN_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
    lock_timer #(.W(TW)) u_timer (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_value(load_value),
        .count(state != IDLE),
        .done(done)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            fail_count  <= '0;
            door_open   <= 1'b0;
            locked_out  <= 1'b0;
            entry_allow <= 1'b1;
        end else begin
            case (state)
                IDLE:
                    if (result_valid && unlocked) begin
                        state       <= OPEN;
                        fail_count  <= '0;
                        door_open   <= 1'b1;
                        entry_allow <= 1'b0;
                    end else if (result_valid && wrong_code) begin
                        fail_count <= fail_next;
                        if (hit_max) begin
                            state       <= LOCKOUT;
                            locked_out  <= 1'b1;
                            entry_allow <= 1'b0;
                        end
                    end
                OPEN:
                    if (relock || done) begin
                        state       <= IDLE;
                        door_open   <= 1'b0;
                        entry_allow <= 1'b1;
                    end
                LOCKOUT:
                    if (done) begin
                        state       <= IDLE;
                        fail_count  <= '0;
                        locked_out  <= 1'b0;
                        entry_allow <= 1'b1;
                    end
                default: begin
                    state       <= IDLE;
                    door_open   <= 1'b0;
                    locked_out  <= 1'b0;
                    entry_allow <= 1'b1;
                end
            endcase
        end
`ifdef LOCK_SUPERVISOR_ALARM_EN
    assign alarm = locked_out;
`else
    assign alarm = 1'b0;
`endif
endmodule

// File: doc/lock_supervisor.md
LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

Interface
REQ-001 SHALL have parameter MAX_FAILS, default 3, meaning consecutive wrong codes that trigger lockout (legal range 1..15).
REQ-002 SHALL have parameter OPEN_CYCLES, default 16, meaning door_open hold length in clk cycles (>=1).
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 64, meaning lockout length in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port result_valid  input  1  one-cycle strobe: unlocked/wrong_code from the code checker are fresh this cycle.
REQ-007 SHALL have port unlocked  input  1  checker verdict, correct code.
REQ-008 SHALL have port wrong_code  input  1  checker verdict, incorrect code.
REQ-009 SHALL have port relock  input  1  manual early close of the door.
REQ-010 SHALL have port entry_allow  output  1  high only in IDLE; gates the upstream enter strobe.
REQ-011 SHALL have port door_open  output  1  relay drive.
REQ-012 SHALL have port locked_out  output  1  lockout active.
REQ-013 SHALL have port fail_count  output  4  current consecutive-failure count.
REQ-014 SHALL have port alarm  output  1  alarm drive (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, OPEN, LOCKOUT; all outputs decoded from registered state/counters, no combinational input-to-output path.
REQ-016 IDLE, result_valid with unlocked=1: SHALL clear fail_count, load timer, enter OPEN; door_open rises the cycle after the strobe.
REQ-017 IDLE, result_valid with unlocked=0 and wrong_code=1: SHALL increment fail_count; if the new value equals MAX_FAILS, SHALL load timer and enter LOCKOUT in the same edge.
REQ-018 result_valid with both verdicts 1: unlocked SHALL take priority; both 0: strobe SHALL be ignored.
REQ-019 OPEN: door_open SHALL stay high exactly OPEN_CYCLES cycles, then return to IDLE.
REQ-020 OPEN with relock=1: SHALL return to IDLE on the next edge; relock in IDLE or LOCKOUT SHALL have no effect.
REQ-021 LOCKOUT: locked_out SHALL stay high exactly LOCKOUT_CYCLES cycles; fail_count SHALL hold MAX_FAILS; on exit SHALL clear fail_count and return to IDLE.
REQ-022 result_valid in OPEN or LOCKOUT SHALL be ignored and SHALL NOT alter fail_count.
REQ-023 Timer SHALL be a single down-counter of width $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1), loaded with N-1, exit on reaching 0; no wrap.
REQ-024 fail_count SHALL never exceed MAX_FAILS.

Reset
REQ-025 Reset SHALL force IDLE, timer 0, fail_count 0, door_open 0, locked_out 0, alarm 0, entry_allow 1.
REQ-026 Reset asserted mid-OPEN or mid-LOCKOUT SHALL abort immediately (asynchronously) with REQ-025 values.

Configuration
REQ-027 With macro LOCK_SUPERVISOR_ALARM_EN defined, alarm SHALL equal locked_out delayed zero cycles (high throughout LOCKOUT).
REQ-028 Without LOCK_SUPERVISOR_ALARM_EN, alarm SHALL be constant 0 and no alarm logic synthesized.

Structure
REQ-029 Shared package lock_pkg SHALL hold the state enum (IDLE/OPEN/LOCKOUT) and the default constants for MAX_FAILS, OPEN_CYCLES, LOCKOUT_CYCLES, fail_count width 4.
REQ-030 Timer SHALL be one sub-module lock_timer (load, load_value, count, done); FSM and fail counter stay in lock_supervisor.

Verification
REQ-031 Reset, then result_valid+unlocked -> door_open high cycles 1..16 after strobe, entry_allow low for same window, fail_count 0.
REQ-032 Three strobes with wrong_code=1 in IDLE -> fail_count 1,2, then locked_out high 64 cycles, fail_count 3, then 0 on exit; alarm tracks locked_out only with LOCK_SUPERVISOR_ALARM_EN.
REQ-033 Two wrong strobes then one unlocked -> fail_count 0, OPEN entered, no lockout.
REQ-034 OPEN, relock at cycle 5 -> door_open low next cycle, IDLE; result_valid+wrong_code during OPEN/LOCKOUT -> fail_count unchanged.
REQ-035 result_valid with unlocked=1 and wrong_code=1 -> OPEN; reset asserted at LOCKOUT cycle 30 -> all outputs to reset values immediately.
